// File: rtl/mfp_ahb_lite_arbiter_if.sv
// AHB-Lite bus bundle used on each side of the two-master arbiter.
// The master modport drives address/control/write data; the slave modport returns read data and response.
interface mfp_ahb_lite_arbiter_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/mfp_ahb_lite_arbiter.sv
// Two-master AHB-Lite arbiter (M0 = core, M1 = DMA/SPI bridge) in front of the bus matrix.
// Define MFP_AHB_ARB_ROUND_ROBIN_EN for round-robin resolution of simultaneous requests.
module mfp_ahb_lite_arbiter #(
    parameter logic DEFAULT_MASTER = 1'b0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    mfp_ahb_lite_arbiter_if.slave  m0,
    mfp_ahb_lite_arbiter_if.slave  m1,
    mfp_ahb_lite_arbiter_if.master mx,
    output logic                   HMASTER
);
    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    logic       addr_owner_q, addr_owner_d;
    logic       data_owner_q, data_owner_d;
    logic       m0_req, m1_req;
    logic       oth_req;
    logic       own_lock;
    logic [1:0] own_trans;
    logic       yield_bus;
    logic       hand_ok;
    logic       handover;

    assign m0_req   = m0.HTRANS[1];
    assign m1_req   = m1.HTRANS[1];
    assign oth_req  = addr_owner_q ? m0_req : m1_req;
    assign own_lock = addr_owner_q ? m1.HMASTLOCK : m0.HMASTLOCK;

`ifdef MFP_AHB_ARB_ROUND_ROBIN_EN
    logic rr_last_q, rr_last_d;
    logic used_q, used_d;
    logic idle_q, idle_d;

    // Both masters leaving an all-idle bus together: the owner is held off for one
    // cycle (matrix sees IDLE) when the round-robin pointer favours the other master.
    assign yield_bus = idle_q & m0_req & m1_req & ~own_lock & used_q &
                       (rr_last_q == addr_owner_q);
    assign hand_ok   = used_q;

    always_comb begin
        rr_last_d = rr_last_q;
        used_d    = used_q;
        idle_d    = idle_q;
        if (handover) begin
            rr_last_d = ~addr_owner_q;
            used_d    = 1'b0;
        end else if (mx.HREADY && own_trans[1]) begin
            used_d    = 1'b1;
        end
        if (mx.HREADY) begin
            idle_d = ~(m0_req | m1_req);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rr_last_q <= 1'b0;
            used_q    <= 1'b1;
            idle_q    <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
            used_q    <= used_d;
            idle_q    <= idle_d;
        end
    end
`else
    assign yield_bus = 1'b0;
    assign hand_ok   = 1'b1;
`endif

    always_comb begin
        own_trans = addr_owner_q ? m1.HTRANS : m0.HTRANS;
        if (yield_bus) begin
            own_trans = HTRANS_IDLE;
        end
    end

    // Bus only changes hands between transfers: owner idle, unlocked, matrix ready.
    assign handover = mx.HREADY & ~own_lock & oth_req & hand_ok &
                      (own_trans == HTRANS_IDLE);

    always_comb begin
        addr_owner_d = addr_owner_q;
        data_owner_d = data_owner_q;
        if (handover) begin
            addr_owner_d = ~addr_owner_q;
        end
        if (mx.HREADY) begin
            data_owner_d = addr_owner_q;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_owner_q <= DEFAULT_MASTER;
            data_owner_q <= DEFAULT_MASTER;
        end else begin
            addr_owner_q <= addr_owner_d;
            data_owner_q <= data_owner_d;
        end
    end

    always_comb begin
        mx.HADDR     = m0.HADDR;
        mx.HBURST    = m0.HBURST;
        mx.HMASTLOCK = m0.HMASTLOCK;
        mx.HPROT     = m0.HPROT;
        mx.HSIZE     = m0.HSIZE;
        mx.HWRITE    = m0.HWRITE;
        if (addr_owner_q) begin
            mx.HADDR     = m1.HADDR;
            mx.HBURST    = m1.HBURST;
            mx.HMASTLOCK = m1.HMASTLOCK;
            mx.HPROT     = m1.HPROT;
            mx.HSIZE     = m1.HSIZE;
            mx.HWRITE    = m1.HWRITE;
        end
        mx.HTRANS = HRESETn ? own_trans : HTRANS_IDLE;
        mx.HWDATA = data_owner_q ? m1.HWDATA : m0.HWDATA;
        HMASTER   = addr_owner_q;
    end

    // The non-owner sees HREADY low only while it holds a request on its port.
    always_comb begin
        m0.HREADY = 1'b1;
        m1.HREADY = 1'b1;
        if (HRESETn) begin
            if (addr_owner_q) begin
                m1.HREADY = yield_bus ? 1'b0 : mx.HREADY;
                m0.HREADY = ~m0_req;
            end else begin
                m0.HREADY = yield_bus ? 1'b0 : mx.HREADY;
                m1.HREADY = ~m1_req;
            end
        end
        m0.HRESP  = HRESETn & ~data_owner_q & mx.HRESP;
        m1.HRESP  = HRESETn &  data_owner_q & mx.HRESP;
        m0.HRDATA = mx.HRDATA;
        m1.HRDATA = mx.HRDATA;
    end
endmodule
